// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch scheduler slice.
//   SS_SIZE / ROB_SIZE / RS_SIZE / FL_SIZE : machine geometry
//   *_W                                     : widths of the free-count buses
//   DISPATCH_STATE                          : recovery FSM states
//   BIT_COUNT_LUT                           : popcount table for an SS_SIZE-bit grant vector
package dispatch_ctrl_pkg;

    localparam int unsigned SS_SIZE  = 3;
    localparam int unsigned ROB_SIZE = 8;
    localparam int unsigned RS_SIZE  = 8;
    localparam int unsigned FL_SIZE  = 32;

    localparam int unsigned CNT_W = $clog2(SS_SIZE) + 1;
    localparam int unsigned ROB_W = $clog2(ROB_SIZE) + 1;
    localparam int unsigned RS_W  = $clog2(RS_SIZE) + 1;
    localparam int unsigned FL_W  = $clog2(FL_SIZE) + 1;

    typedef enum logic [1:0] {DC_RUN, DC_FLUSH, DC_REFILL} DISPATCH_STATE;

    // Indexed by the 3-bit dispatch vector.
    localparam logic [CNT_W-1:0] BIT_COUNT_LUT [2**SS_SIZE] =
        '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

endpackage

// File: rtl/dispatch_grant.sv
// In-order grant walk over SS superscalar slots (slot SS-1 oldest).
//   valid_i    : slot holds an instruction
//   has_dest_i : slot consumes one free-list entry
//   rob_free_i / rs_free_i / fl_free_i : available resource counts
//   grant_o    : per-slot grant, contiguous from the oldest slot
//   blocked_o  : a valid slot reached by the walk failed its resource check
module dispatch_grant #(
    parameter int unsigned SS    = 3,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned RS_W  = 4,
    parameter int unsigned FL_W  = 6
) (
    input  logic [SS-1:0]    valid_i,
    input  logic [SS-1:0]    has_dest_i,
    input  logic [ROB_W-1:0] rob_free_i,
    input  logic [RS_W-1:0]  rs_free_i,
    input  logic [FL_W-1:0]  fl_free_i,
    output logic [SS-1:0]    grant_o,
    output logic             blocked_o
);

    localparam int unsigned IDX_W = (SS > 1) ? $clog2(SS) : 1;

    // Running totals carry one extra bit so a zero free count still compares cleanly.
    logic [ROB_W:0]   rob_n;
    logic [RS_W:0]    rs_n;
    logic [FL_W:0]    fl_n;
    logic [FL_W:0]    fl_need;
    logic             walking;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o   = '0;
        blocked_o = 1'b0;
        rob_n     = '0;
        rs_n      = '0;
        fl_n      = '0;
        fl_need   = '0;
        walking   = 1'b1;
        idx       = '0;
        for (int unsigned k = 0; k < SS; k++) begin
            idx     = IDX_W'(SS - 1 - k);
            fl_need = fl_n + {{FL_W{1'b0}}, has_dest_i[idx]};
            if (walking) begin
                if (!valid_i[idx]) begin
                    // A hole ends the walk without counting as a stall.
                    walking = 1'b0;
                end else if ((rob_n + 1'b1) <= {1'b0, rob_free_i} &&
                             (rs_n  + 1'b1) <= {1'b0, rs_free_i}  &&
                             fl_need        <= {1'b0, fl_free_i}) begin
                    grant_o[idx] = 1'b1;
                    rob_n        = rob_n + 1'b1;
                    rs_n         = rs_n + 1'b1;
                    fl_n         = fl_need;
                end else begin
                    blocked_o = 1'b1;
                    walking   = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch scheduler: grants fetch slots in program order against registered
// ROB/RS/free-list counts and sequences mispredict recovery (FLUSH/REFILL).
//   clock, reset              : clock, synchronous active-high reset
//   inst_valid, inst_has_dest : fetch slot status
//   *_free_next               : next-cycle free counts from ROB/RS/free list
//   branch_not_taken          : mispredict flush
//   dispatch_en/dispatch_count: grants and their popcount
//   rob_enable, stall, recovering, stall_cycles : status outputs
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SS_SIZE-1:0] inst_valid,
    input  logic [SS_SIZE-1:0] inst_has_dest,
    input  logic [ROB_W-1:0]   rob_free_rows_next,
    input  logic [RS_W-1:0]    rs_free_next,
    input  logic [FL_W-1:0]    fl_free_next,
    input  logic               branch_not_taken,
    output logic [SS_SIZE-1:0] dispatch_en,
    output logic [CNT_W-1:0]   dispatch_count,
    output logic               rob_enable,
    output logic               stall,
    output logic               recovering,
    output logic [31:0]        stall_cycles
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES) + 1;

    DISPATCH_STATE      state_q, state_d;
    logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [ROB_W-1:0]   rob_free_q;
    logic [RS_W-1:0]    rs_free_q;
    logic [FL_W-1:0]    fl_free_q;
    logic [31:0]        stall_cycles_q, stall_cycles_d;
    logic [SS_SIZE-1:0] grant;
    logic               blocked;

    dispatch_grant #(
        .SS    (SS_SIZE),
        .ROB_W (ROB_W),
        .RS_W  (RS_W),
        .FL_W  (FL_W)
    ) u_grant (
        .valid_i    (inst_valid),
        .has_dest_i (inst_has_dest),
        .rob_free_i (rob_free_q),
        .rs_free_i  (rs_free_q),
        .fl_free_i  (fl_free_q),
        .grant_o    (grant),
        .blocked_o  (blocked)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= DC_RUN;
            flush_cnt_q    <= '0;
            rob_free_q     <= ROB_W'(ROB_SIZE);
            rs_free_q      <= RS_W'(RS_SIZE);
            fl_free_q      <= FL_W'(FL_SIZE);
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            rob_free_q     <= rob_free_rows_next;
            rs_free_q      <= rs_free_next;
            fl_free_q      <= fl_free_next;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (branch_not_taken) begin
            // A mispredict in any state (re)starts the flush window.
            state_d     = DC_FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
        end else begin
            case (state_q)
                DC_RUN:    state_d = DC_RUN;
                DC_FLUSH: begin
                    if (flush_cnt_q == '0) state_d = DC_REFILL;
                    else                   flush_cnt_d = flush_cnt_q - 1'b1;
                end
                DC_REFILL: state_d = DC_RUN;
                default:   state_d = DC_RUN;
            endcase
        end
    end

    always_comb begin
        dispatch_en = '0;
        rob_enable  = 1'b1;
        stall       = 1'b0;
        recovering  = 1'b0;
        if (!reset) begin
            case (state_q)
                DC_RUN: begin
                    if (branch_not_taken) begin
                        stall = |inst_valid;
                    end else begin
                        dispatch_en = grant;
                        stall       = blocked;
                    end
                end
                DC_FLUSH: begin
                    rob_enable = 1'b0;
                    recovering = 1'b1;
                    stall      = |inst_valid;
                end
                default: begin
                    recovering = 1'b1;
                    stall      = |inst_valid;
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    assign dispatch_count = BIT_COUNT_LUT[dispatch_en];
    assign stall_cycles   = stall_cycles_q;

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
Per-cycle dispatch scheduler in front of the ROB, RS and free list. Grants superscalar dispatch slots in program order, limited by the registered free-resource counts the ROB, RS and free list report. Sequences branch-misprediction recovery with a FLUSH/REFILL state machine that holds dispatch off while those structures clear. Drives ROB dispatch_en and enable, and acknowledges fetch slots.

Parameters:
SS_SIZE, `SS_SIZE (3), superscalar width; slot SS_SIZE-1 is oldest, same convention as ROB.
ROB_SIZE, `ROB_SIZE (8), ROB entries.
RS_SIZE, `RS_SIZE (8), reservation station entries.
FL_SIZE, `FL_SIZE (32), free-list entries.
FLUSH_CYCLES, 2, dispatch-blocked cycles after a mispredict, FLUSH_CYCLES >= 1.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
inst_valid  in  SS_SIZE  fetch slot holds an instruction
inst_has_dest  in  SS_SIZE  slot needs a new physical register
rob_free_rows_next  in  $clog2(ROB_SIZE)+1  ROB free_rows_next
rs_free_next  in  $clog2(RS_SIZE)+1  RS free count for next cycle
fl_free_next  in  $clog2(FL_SIZE)+1  free-list count for next cycle
branch_not_taken  in  1  mispredict flush, same signal the ROB uses
dispatch_en  out  SS_SIZE  per-slot grant to ROB/RS/free list
dispatch_count  out  $clog2(SS_SIZE)+1  popcount of dispatch_en, to fetch
rob_enable  out  1  ROB enable
stall  out  1  a valid slot was not granted this cycle
recovering  out  1  state != RUN
stall_cycles  out  32  saturating count of stall cycles

Behaviour:
- Registers rob_free_q, rs_free_q and fl_free_q load the *_next inputs every clock. Grant logic uses only these registered values, so the inputs' combinational paths never reach dispatch_en.
- Reset loads rob_free_q=ROB_SIZE, rs_free_q=RS_SIZE, fl_free_q=FL_SIZE, state=RUN, flush_cnt=0, stall_cycles=0.
- Output values during reset:
  - dispatch_en=0, dispatch_count=0, stall=0, recovering=0, rob_enable=1.
- Grant in RUN: walk slots from i=SS_SIZE-1 down to 0 with cumulative needs rob_n, rs_n, fl_n. Slot i is granted only if all of the following hold:
  - inst_valid[i]
  - every older valid slot was granted (in-order, no holes)
  - rob_n+1 <= rob_free_q
  - rs_n+1 <= rs_free_q
  - fl_n+inst_has_dest[i] <= fl_free_q
- On the first failing valid slot, stop granting; all younger slots are 0.
- An invalid slot ends the walk. Younger slots are not granted and no stall is raised for them.
- Combinational; dispatch_en is valid in the same cycle as inst_valid.
- stall=1 iff state==RUN and some valid slot is not granted, or state!=RUN and any inst_valid.
- stall_cycles increments on stall and saturates at 2^32-1.
- FSM:
  - RUN: branch_not_taken -> FLUSH, flush_cnt=FLUSH_CYCLES-1. Grants are suppressed in the cycle branch_not_taken is high.
  - FLUSH: dispatch_en=0 and rob_enable=0. When flush_cnt==0 -> REFILL; otherwise decrement.
  - REFILL: dispatch_en=0, rob_enable=1. One cycle only, so the registered counts reload from the cleared structures. Then -> RUN.
- branch_not_taken in FLUSH or REFILL restarts FLUSH with flush_cnt=FLUSH_CYCLES-1.
- recovering=1 in FLUSH and REFILL.
- Reset mid-recovery returns to RUN next cycle. Reset has priority over branch_not_taken.
- Arithmetic:
  - Cumulative counts are widened by one bit, so no overflow occurs when a count is 0.
  - A zero count blocks every slot that needs that resource.
- Boundaries:
  - rob_free_q=0: no grants; stall if any slot is valid.
  - ROB exactly fits (rob_free_q=k): the oldest k valid slots are granted.
  - fl_free_q=0: slots without a destination can still be granted, up to the first slot that has one.

Decomposition:
- Shared package sys_defs.vh already supplies `SS_SIZE, `ROB_SIZE, `RS_SIZE, `FL_SIZE and BIT_COUNT_LUT; use BIT_COUNT_LUT for dispatch_count.
- Add typedef enum logic [1:0] {DC_RUN, DC_FLUSH, DC_REFILL} DISPATCH_STATE to sys_defs.vh.
- One sub-module, dispatch_grant, holds the purely combinational in-order grant walk. It is parameterised by SS_SIZE and the count widths, and is reusable for the LSQ later.

Test Plan:
- Reset, then inputs rob=8, rs=8, fl=32 and inst_valid=111. Next cycle: dispatch_en=111, dispatch_count=3, stall=0.
- rob_free_rows_next=2 registered, inst_valid=111. Result: dispatch_en=110, stall=1, stall_cycles increments by 1.
- fl_free_next=1, inst_has_dest=111, inst_valid=111, other resources plentiful. Result: dispatch_en=100. With inst_has_dest=101 instead: dispatch_en=110.
- inst_valid=101. Result: dispatch_en=100, and slot 0 is not granted across the hole.
- branch_not_taken pulsed with FLUSH_CYCLES=2:
  - same cycle: dispatch_en=000.
  - next 2 cycles: FLUSH, rob_enable=0, recovering=1.
  - then 1 cycle: REFILL, rob_enable=1.
  - then RUN, granting from the reloaded counts.
- reset asserted during FLUSH. Next cycle: state=RUN, stall_cycles=0, rob_enable=1, full grants with default counts.
